// File: rtl/count_display.sv
// count_display: samples an 8-bit count, converts it to three BCD digits with
// a sequential shift-add-3 engine, and time-multiplexes the digits onto an
// active-low common-anode 7-segment display.
//
// Handshake note: there is no valid/ready pair here. `value` is treated as a
// level; it is sampled only while the converter is IDLE, and `busy` is high
// from the load edge until the edge that writes `bcd`.
module count_display #(
  parameter int REFRESH_DIV = 50000,  // cycles each digit stays lit, >= 2
  parameter bit BLANK_LZ    = 1'b1    // 1: blank leading zeros
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [2:0]  an,
  output logic [6:0]  seg,
  output logic [1:0]  dbg_state     // converter FSM state for checkers
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [7:0]    r_last_val;
  logic [19:0]   r_shift;
  logic [2:0]    r_iter;
  logic [11:0]   r_bcd;
  logic          r_busy;

  logic [CW-1:0] r_refresh;
  logic [1:0]    r_sel;
  logic [2:0]    r_an;
  logic [6:0]    r_seg;

  // Add-3 correction of each BCD nibble, then the left shift
  logic [3:0]    w_hun_adj;
  logic [3:0]    w_ten_adj;
  logic [3:0]    w_one_adj;
  logic [19:0]   w_adjusted;
  logic [19:0]   w_shift_next;

  assign w_hun_adj    = (r_shift[19:16] >= 4'd5) ? r_shift[19:16] + 4'd3 : r_shift[19:16];
  assign w_ten_adj    = (r_shift[15:12] >= 4'd5) ? r_shift[15:12] + 4'd3 : r_shift[15:12];
  assign w_one_adj    = (r_shift[11:8]  >= 4'd5) ? r_shift[11:8]  + 4'd3 : r_shift[11:8];
  assign w_adjusted   = {w_hun_adj, w_ten_adj, w_one_adj, r_shift[7:0]};
  assign w_shift_next = {w_adjusted[18:0], 1'b0};

  // Converter FSM: load on a new value, eight shift-add-3 steps, publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_val <= 8'd0;
      r_shift    <= 20'd0;
      r_iter     <= 3'd0;
      r_bcd      <= 12'h000;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (value != r_last_val) begin
            r_shift    <= {12'b0, value};
            r_last_val <= value;
            r_iter     <= 3'd0;
            r_state    <= S_SHIFT;
            r_busy     <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_shift <= w_shift_next;
          r_iter  <= r_iter + 3'd1;
          if (r_iter == 3'd7) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_bcd   <= r_shift[19:8];
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Scan: refresh wrap advances the digit select; an/seg follow the next select
  logic          w_wrap;
  logic [1:0]    w_sel_next;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [2:0]    w_an_next;
  logic [6:0]    w_seg_next;

  assign w_wrap = (r_refresh == REFRESH_LAST);

  // Select logic, digit pick and leading-zero blanking for the next scan slot
  always_comb begin
    w_sel_next = r_sel;
    if (w_wrap) begin
      w_sel_next = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
    end

    w_digit   = r_bcd[3:0];
    w_blank   = 1'b0;
    w_an_next = 3'b110;
    case (w_sel_next)
      2'd1: begin
        w_digit   = r_bcd[7:4];
        w_blank   = BLANK_LZ && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
        w_an_next = 3'b101;
      end
      2'd2: begin
        w_digit   = r_bcd[11:8];
        w_blank   = BLANK_LZ && (r_bcd[11:8] == 4'd0);
        w_an_next = 3'b011;
      end
      default: begin
        w_digit   = r_bcd[3:0];
        w_blank   = 1'b0;
        w_an_next = 3'b110;
      end
    endcase

    w_seg_next = w_blank ? 7'b1111111 : seg_decode(w_digit);
  end

  // Active-low segment pattern, [0]=a .. [6]=g; out-of-range nibbles are blank
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Refresh counter, digit select and the registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
      r_sel     <= 2'd0;
      r_an      <= 3'b110;
      r_seg     <= 7'b1000000;
    end else begin
      r_refresh <= w_wrap ? '0 : r_refresh + 1'b1;
      r_sel     <= w_sel_next;
      r_an      <= w_an_next;
      r_seg     <= w_seg_next;
    end
  end

  assign busy      = r_busy;
  assign bcd       = r_bcd;
  assign an        = r_an;
  assign seg       = r_seg;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_count_display.sv
// Bench for count_display: table vectors, hand-written corner sequences and a
// randomized run checked against an arithmetic decimal-digit model.
module tb_count_display;

  localparam int RDIV = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  value;
  logic        busy, busy_nb;
  logic [11:0] bcd, bcd_nb;
  logic [2:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;
  logic [1:0]  dbg, dbg_nb;

  always #5 clk = ~clk;

  count_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .value(value), .busy(busy), .bcd(bcd),
    .an(an), .seg(seg), .dbg_state(dbg)
  );

  count_display #(.REFRESH_DIV(RDIV), .BLANK_LZ(1'b0)) u_nb (
    .clk(clk), .rst(rst), .value(value), .busy(busy_nb), .bcd(bcd_nb),
    .an(an_nb), .seg(seg_nb), .dbg_state(dbg_nb)
  );

  // non-reset edges since the last reset edge; drives the scan model
  int n_edges = 0;
  always @(posedge clk) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  // ---------------- model ----------------
  logic [6:0] seg_tab [10];
  int total = 0;
  int bad   = 0;

  function automatic logic [11:0] model_bcd(input int v);
    model_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int model_sel();
    model_sel = (n_edges / RDIV) % 3;
  endfunction

  function automatic logic [2:0] model_an(input int sel);
    logic [2:0] oh;
    oh = 3'(1 << sel);
    model_an = ~oh;
  endfunction

  function automatic logic [6:0] model_seg(input int v, input int sel, input bit blank_lz);
    int h, t, o, d;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    d = (sel == 0) ? o : (sel == 1) ? t : h;
    if (blank_lz && ((sel == 2 && h == 0) || (sel == 1 && h == 0 && t == 0)))
      model_seg = 7'b1111111;
    else
      model_seg = seg_tab[d];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // wait (bounded) for busy to drop, counting the busy cycles seen
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  val;
    logic [11:0] exp_bcd;
    logic [6:0]  s_one;
    logic [6:0]  s_ten;
    logic [6:0]  s_hun;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cnt;
    int sel;
    logic [6:0] exp_s;
    int v1, v2, gap;

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    vecs[0] = '{8'd255, 12'h255, 7'b0010010, 7'b0010010, 7'b0100100};
    vecs[1] = '{8'd7,   12'h007, 7'b1111000, 7'b1111111, 7'b1111111};
    vecs[2] = '{8'd100, 12'h100, 7'b1000000, 7'b1000000, 7'b1111001};
    vecs[3] = '{8'd12,  12'h012, 7'b0100100, 7'b1111001, 7'b1111111};
    vecs[4] = '{8'd99,  12'h099, 7'b0010000, 7'b0010000, 7'b1111111};
    vecs[5] = '{8'd0,   12'h000, 7'b1000000, 7'b1111111, 7'b1111111};

    // ---- reset ----
    rst = 1'b1; value = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an, 3'b110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_bcd", bcd, 12'h000);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_conv_busy", busy, 0);
    end
    chk("no_conv_bcd", bcd, 12'h000);

    // ---- table vectors: latency, result, full scan frame on both blanking modes ----
    for (int i = 0; i < 6; i++) begin
      value = vecs[i].val;
      @(negedge clk);
      wait_idle(cnt);
      chk("busy_len", cnt, 9);
      chk("vec_bcd", bcd, vecs[i].exp_bcd);
      chk("vec_bcd_nb", bcd_nb, vecs[i].exp_bcd);
      @(posedge clk);
      for (int c = 0; c < 3 * RDIV; c++) begin
        @(negedge clk);
        sel = model_sel();
        exp_s = (sel == 0) ? vecs[i].s_one : (sel == 1) ? vecs[i].s_ten : vecs[i].s_hun;
        chk("vec_an", an, model_an(sel));
        chk("vec_seg", seg, exp_s);
        chk("vec_an_nb", an_nb, model_an(sel));
        chk("vec_seg_nb", seg_nb, model_seg(vecs[i].val, sel, 1'b0));
      end
    end

    // ---- change mid-conversion: 12 then 200 before E3 ----
    value = 8'd12;
    repeat (3) @(posedge clk);       // E0, E1, E2
    @(negedge clk);
    value = 8'd200;
    wait_idle(cnt);                  // negedge after E9
    chk("mid_first_bcd", bcd, 12'h012);
    chk("mid_first_busy", busy, 0);
    @(posedge clk);                  // E10 reloads
    @(negedge clk);
    chk("mid_reload_busy", busy, 1);
    repeat (9) @(posedge clk);       // E11..E19
    @(negedge clk);
    chk("mid_second_bcd", bcd, 12'h200);
    chk("mid_second_busy", busy, 0);

    // ---- reset mid-conversion: 99, rst at E4 ----
    @(negedge clk);
    value = 8'd99;
    repeat (4) @(posedge clk);       // E0..E3
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);                  // E4 with reset
    @(negedge clk);
    chk("rmid_busy", busy, 0);
    chk("rmid_bcd", bcd, 12'h000);
    chk("rmid_an", an, 3'b110);
    chk("rmid_seg", seg, 7'b1000000);
    rst = 1'b0;
    @(posedge clk);                  // first non-reset edge loads
    @(negedge clk);
    chk("rmid_restart_busy", busy, 1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("rmid_bcd_final", bcd, 12'h099);
    chk("rmid_busy_final", busy, 0);

    // ---- sweep 0..255 ----
    for (int v = 0; v < 256; v++) begin
      value = 8'(v);
      @(negedge clk);
      wait_idle(cnt);
      chk("sweep_bcd", bcd, model_bcd(v));
    end

    // ---- random pairs with a change landing anywhere in the conversion ----
    for (int k = 0; k < 30; k++) begin
      v1  = $urandom_range(0, 255);
      v2  = $urandom_range(0, 255);
      gap = $urandom_range(0, 12);
      value = 8'(v1);
      repeat (gap) @(negedge clk);
      value = 8'(v2);
      repeat (30) @(negedge clk);
      chk("rand_bcd", bcd, model_bcd(v2));
      chk("rand_bcd_nb", bcd_nb, model_bcd(v2));
      chk("rand_busy", busy, 0);
      for (int c = 0; c < RDIV; c++) begin
        @(negedge clk);
        sel = model_sel();
        chk("rand_seg", seg, model_seg(v2, sel, 1'b1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_display.md
# count_display

Reader-side display driver for the 8-bit running count from the counter. It samples the count and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto an active-low common-anode 7-segment display. It sits between the counter's `out` bus and the board display pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; must be ≥ 2.
- `BLANK_LZ`, default 1: 1 blanks leading zeros (hundreds and tens); 0 always shows all three digits.
- `clk` in 1: single system clock; everything is registered on its rising edge.
- `rst` in 1: reset is synchronous and active-high. One clock (`clk`); all state is sampled on the rising edge while `rst`=1.
- `value` in 8: count to display, unsigned 0–255.
- `busy` out 1: 1 while a conversion is in progress.
- `bcd` out 12: last completed conversion; [11:8] hundreds, [7:4] tens, [3:0] ones.
- `an` out 3: digit enables, active-low; [0] ones, [1] tens, [2] hundreds.
- `seg` out 7: segments, active-low; [0]=a … [6]=g.

## Operation
- **Reset values:** state IDLE, `last_val`=0, `bcd`=12'h000, `busy`=0, scan select=0, refresh counter=0, `an`=3'b110, `seg`=7'b1000000 (digit "0").
- **Converter FSM**
  - IDLE: if `value` != `last_val`, load the 20-bit shift register {12'b0, value}, set `last_val` <= `value`, clear the iteration count, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble that is ≥ 5, then shift left by 1. Go to DONE after the 8th shift.
  - DONE: `bcd` <= shift register [19:8], go to IDLE.
  - `busy` = (state != IDLE).
- **Changes during a conversion:** `value` is not sampled in SHIFT or DONE. On return to IDLE it is compared against `last_val` again. Only the final value is guaranteed to be converted; intermediate values may be skipped.
- **Scan**
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, scan select advances 0→1→2→0.
  - `an` is the one-hot-low decode of scan select.
  - `seg` is the 7-segment decode of the selected `bcd` nibble.
- **Blanking (BLANK_LZ=1)**
  - Hundreds digit is blank when it is 0.
  - Tens digit is blank when hundreds = 0 and tens = 0.
  - Ones digit is never blank.
  - Blank drives `seg`=7'b1111111; `an` still cycles normally.
- **Decode table (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles > 9 cannot occur; they decode to blank.
- **Registered outputs:** `an` and `seg` are updated together on the same edge.

## Timing
- **Conversion latency:** `value` changes before edge E0 (FSM in IDLE).
  - E0: load, `busy` rises.
  - E1–E8: eight shifts.
  - E9: `bcd` updates, `busy` falls.
  - Total: 9 cycles of `busy`=1; new `bcd` visible after E9.
- **Back-to-back conversions:** if `value` differs from `last_val` in the IDLE cycle after E9, the next conversion loads at E10. There is a minimum 1 IDLE cycle between conversions.
- **Display update:** `seg` reflects a new `bcd` on the edge after `bcd` changes, for whichever digit is currently selected.
- **Scan timing:** each digit is lit for exactly REFRESH_DIV cycles; the full frame is 3×REFRESH_DIV.
- **Reset during SHIFT or DONE:** the conversion is aborted and `bcd` is not written. All outputs take their reset values on that edge. If `value` != 0 after reset is released, a fresh conversion starts on the first non-reset edge.
- **Simultaneous events:** refresh wrap and DONE on the same edge cause `seg` to decode the old `bcd` for one cycle. The new `bcd` appears on the next edge. This is accepted behaviour.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `value`=0 → `an`=110, `seg`=1000000, `bcd`=000, `busy`=0; no conversion after release.
- **Latency and max value:** `value`=255 from IDLE → `busy`=1 for exactly 9 cycles; `bcd`=12'h255. With REFRESH_DIV=4, `seg` sequence = 0010010, 0010010, 0100100 on `an`=110, 101, 011.
- **Leading-zero blanking:** `value`=7, BLANK_LZ=1 → `bcd`=12'h007; ones `seg`=1111000; tens and hundreds `seg`=1111111. With BLANK_LZ=0, tens and hundreds show 1000000. Also `value`=100 → tens shows "0" (not blanked).
- **Change mid-conversion:** `value`=12 then 200 at E3 → first result `bcd`=12'h012. A second conversion loads at E10 and gives `bcd`=12'h200 after E19.
- **Reset mid-conversion:** `value`=99, assert `rst` at E4 for 1 cycle → `bcd` stays 000 and `busy`=0. A new conversion starts right after release; `bcd`=12'h099 after 9 more cycles.
- **Sweep:** drive `value` 0..255, waiting for `busy` to fall each step → `bcd` equals the decimal of `value` for all 256 values; the error count must be 0.
